// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encodings, the
// golden mask of the 4-input function unit and the settle-timer load helper.
package truth_table_sweeper_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [15:0] TT_F_GOLDEN = 16'h212F;

  localparam int SETTLE_W = 4;

  // The timer reaches zero on the last WAIT cycle, so it is loaded with SETTLE-1.
  function automatic logic [SETTLE_W-1:0] settle_load(input int settle);
    return (settle > 0) ? SETTLE_W'(settle - 1) : '0;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times the WAIT phase between driving a vector
// and sampling the function unit output.
module tt_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of a combinational function unit, samples its
// output after a settle time and compares the captured table with a golden mask.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                      N_IN     = 4,
  parameter int                      SETTLE   = 1,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED = TT_F_GOLDEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  output logic [N_IN-1:0]        vec,
  input  logic                   fs,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   result,
  output logic [N_IN:0]          fail_cnt,
  output logic [N_IN-1:0]        first_fail,
  output logic                   pass
);

  localparam logic [N_IN-1:0]     LAST_VEC    = '1;
  localparam logic [N_IN:0]       FAIL_MAX    = {1'b1, {N_IN{1'b0}}};
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = settle_load(SETTLE);
  localparam logic [2:0]          AFTER_DRIVE = (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;

  logic [2:0] state;
  logic       settle_zero;
  logic       fs_miss;

  assign fs_miss = fs ^ EXPECTED[vec];

  tt_settle_timer #(
    .W(SETTLE_W)
  ) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_DRIVE),
    .load_val (SETTLE_LOAD),
    .en       (state == ST_WAIT),
    .zero     (settle_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      vec        <= '0;
      result     <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            result     <= '0;
            fail_cnt   <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
            vec        <= '0;
            busy       <= 1'b1;
            state      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state <= AFTER_DRIVE;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= ST_IDLE;
          end else if (settle_zero) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // An abort here drops the pending sample; the table keeps only committed entries.
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            result[vec] <= fs;
            if (fs_miss) begin
              if (fail_cnt != FAIL_MAX) fail_cnt <= fail_cnt + 1'b1;
              if (fail_cnt == '0) first_fail <= vec;
            end
            if (vec == LAST_VEC) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (fail_cnt == '0) && !fs_miss;
              state <= ST_DONE;
            end else begin
              vec   <= vec + 1'b1;
              state <= ST_DRIVE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: a SETTLE=1 and a SETTLE=0 instance
// are swept with directed and random truth tables against a table-level model.
module tb_truth_table_sweeper;

  localparam logic [15:0] GOLD = 16'h212F;

  typedef struct {
    logic [15:0] result;
    logic [4:0]  fails;
    logic [3:0]  first;
    logic        pass;
    int          lat;
    int          start_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, abort = 1'b0, fs = 1'b0;
  logic [3:0]  vec;
  logic        busy, done, pass;
  logic [15:0] result;
  logic [4:0]  fail_cnt;
  logic [3:0]  first_fail;

  logic        reset0 = 1'b1, start0 = 1'b0, abort0 = 1'b0;
  logic        fs0;
  logic [3:0]  vec0;
  logic        busy0, done0, pass0;
  logic [15:0] result0;
  logic [4:0]  fail0;
  logic [3:0]  first0;

  logic [15:0] tt_cur = 16'h0000;
  logic [15:0] tt0 = 16'h0000;
  logic [3:0]  vec_prev = 4'h0;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t sb0[$];
  int   trace[$];
  exp_t me, me0;
  bit   ok;

  truth_table_sweeper dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .vec(vec), .fs(fs),
    .busy(busy), .done(done), .result(result), .fail_cnt(fail_cnt),
    .first_fail(first_fail), .pass(pass)
  );

  truth_table_sweeper #(.SETTLE(0)) dut0 (
    .clk(clk), .reset(reset0), .start(start0), .abort(abort0), .vec(vec0), .fs(fs0),
    .busy(busy0), .done(done0), .result(result0), .fail_cnt(fail0),
    .first_fail(first0), .pass(pass0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Function unit with a one-cycle glitch after every vector change.
  always @(negedge clk) begin
    fs = (vec !== vec_prev) ? 1'($urandom) : tt_cur[vec];
    vec_prev = vec;
  end
  assign fs0 = tt0[vec0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] tt, input int settle);
    exp_t e;
    e.result = tt;
    e.fails = '0;
    e.first = '0;
    for (int i = 0; i < 16; i++) begin
      if (tt[i] != GOLD[i]) begin
        if (e.fails == 0) e.first = i[3:0];
        e.fails = e.fails + 5'd1;
      end
    end
    e.pass = (e.fails == 0);
    e.lat = 16 * (2 + settle);
    e.start_cyc = 0;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e, input logic [15:0] r,
                         input logic [4:0] fc, input logic [3:0] ff, input logic p);
    check({tag, "_result"}, 32'(r), 32'(e.result));
    check({tag, "_fail_cnt"}, 32'(fc), 32'(e.fails));
    if (e.fails != 0) check({tag, "_first_fail"}, 32'(ff), 32'(e.first));
    check({tag, "_pass"}, 32'(p), 32'(e.pass));
    check({tag, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) trace.push_back(int'(vec));
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        me = sb.pop_front();
        compare("sweep", me, result, fail_cnt, first_fail, pass);
        ok = (trace.size() == me.lat);
        foreach (trace[i]) if (trace[i] != i / (me.lat / 16)) ok = 1'b0;
        check("vec_order", 32'(ok), 32'd1);
      end
      trace.delete();
    end
  end

  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      if (sb0.size() == 0) begin
        check("unexpected_done0", 32'(done0), 32'd0);
      end else begin
        me0 = sb0.pop_front();
        compare("sweep0", me0, result0, fail0, first0, pass0);
      end
    end
  end

  task automatic sweep(input logic [15:0] tt, input int poke_vec, input bit poke_done);
    exp_t e;
    int   k;
    bit   poked;
    e = model(tt, 1);
    @(negedge clk);
    tt_cur = tt;
    trace.delete();
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    poked = 1'b0;
    while (done !== 1'b1 && k < 200) begin
      if (poke_vec >= 0 && !poked && vec == poke_vec[3:0]) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("sweep_timeout", 32'(k < 200), 32'd1);
    if (poke_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_ignored", 32'({busy, done}), 32'd0);
    end
  endtask

  task automatic sweep0(input logic [15:0] tt);
    exp_t e;
    int   k;
    e = model(tt, 0);
    @(negedge clk);
    tt0 = tt;
    e.start_cyc = cyc + 1;
    sb0.push_back(e);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while (done0 !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("sweep0_timeout", 32'(k < 200), 32'd1);
  endtask

  task automatic abort_at(input logic [15:0] tt, input int at, input int extra);
    int          k;
    logic [15:0] mask, diff;
    logic [4:0]  nf;
    logic [3:0]  ff;
    @(negedge clk);
    tt_cur = tt;
    trace.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (vec != at[3:0] && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("abort_reach", 32'(k < 200), 32'd1);
    repeat (extra) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    mask = 16'((32'd1 << at) - 32'd1);
    diff = (tt ^ GOLD) & mask;
    nf = '0;
    ff = '0;
    for (int i = 0; i < 16; i++) begin
      if (diff[i]) begin
        if (nf == 0) ff = i[3:0];
        nf = nf + 5'd1;
      end
    end
    check("abort_busy_pass", 32'({busy, pass}), 32'd0);
    check("abort_result", 32'(result), 32'(tt & mask));
    check("abort_fail_cnt", 32'(fail_cnt), 32'(nf));
    if (nf != 0) check("abort_first_fail", 32'(first_fail), 32'(ff));
    k = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) k++;
    end
    check("abort_no_done", 32'(k), 32'd0);
  endtask

  initial begin
    reset = 1'b1; reset0 = 1'b1; start = 1'b1; start0 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {vec, result, fail_cnt, first_fail, busy, done, pass}, 32'd0);
    check("reset_outputs0", {vec0, result0, fail0, first0, busy0, done0, pass0}, 32'd0);
    reset = 1'b0; reset0 = 1'b0; start = 1'b0; start0 = 1'b0;
    repeat (5) @(negedge clk);
    check("no_sweep_after_reset", 32'({busy, done, busy0, done0}), 32'd0);

    sweep(GOLD, -1, 1'b0);
    sweep(16'h0000, -1, 1'b0);
    sweep(16'hFFFF, -1, 1'b0);
    sweep(GOLD, 6, 1'b1);
    sweep(~GOLD, -1, 1'b0);

    abort_at(GOLD, 5, 0);
    for (int i = 0; i < 3; i++)
      abort_at(16'($urandom), int'($urandom_range(15, 0)), int'($urandom_range(2, 0)));

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start", 32'(busy), 32'd0);
    @(negedge clk);
    check("abort_beats_start_hold", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) sweep(16'($urandom), -1, 1'b0);

    sweep0(GOLD);
    sweep0(16'($urandom));
    sweep0(16'($urandom));

    @(negedge clk);
    tt0 = GOLD;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (12) @(negedge clk);
    reset0 = 1'b1;
    @(negedge clk);
    check("reset_mid_sweep0", {vec0, result0, fail0, first0, busy0, done0, pass0}, 32'd0);
    reset0 = 1'b0;
    repeat (40) @(negedge clk);
    check("reset_mid_idle0", 32'(busy0), 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("scoreboard0_drained", 32'(sb0.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
